// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_e    : deserialiser FSM state encoding
//   DataBits      : data bits per 8N1 frame
//   clks_per_bit  : system clocks per serial bit
//   mid_count     : counter value at the centre of a bit period
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

    localparam int unsigned DataBits = 8;

    function automatic int unsigned clks_per_bit(input int unsigned sys_clock,
                                                 input int unsigned baudrate);
        return sys_clock / baudrate;
    endfunction

    function automatic int unsigned mid_count(input int unsigned cpb);
        return cpb / 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/wdata_i: write request and data (ignored when full unless a pop frees a slot)
//   pop_i         : read request (ignored when empty)
//   rdata_o       : head entry, zero while empty
//   full_o/empty_o: occupancy flags
//   count_o       : current occupancy
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned PtrW  = AddrW + 1;
    // Pointers differ only in the wrap bit when the FIFO is full.
    localparam logic [PtrW-1:0] FullXor = PtrW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_q, wr_d;
    logic [PtrW-1:0]  rd_q, rd_d;
    logic             push_ok, pop_ok;

    always_comb begin
        empty_o = (wr_q == rd_q);
        full_o  = ((wr_q ^ rd_q) == FullXor);
        pop_ok  = pop_i && !empty_o;
        // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
        push_ok = push_i && (!full_o || pop_ok);
        wr_d    = push_ok ? wr_q + PtrW'(1) : wr_q;
        rd_d    = pop_ok  ? rd_q + PtrW'(1) : rd_q;
        count_o = wr_q - rd_q;
        rdata_o = empty_o ? '0 : mem_q[rd_q[AddrW-1:0]];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q[AddrW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Buffered 8N1 UART receiver with mid-bit majority sampling and a FWFT receive FIFO.
//   i_SysClock : system clock
//   i_ResetN   : asynchronous active-low reset
//   i_RxSerial : asynchronous serial line, idle high
//   o_RxByte   : byte at FIFO head (valid when o_RxValid)
//   o_RxValid  : FIFO not empty
//   i_RxReady  : consumer pops head when o_RxValid & i_RxReady
//   o_Count    : FIFO occupancy
//   o_FrameErr : one-cycle pulse when a stop bit is sampled low
//   o_Overflow : sticky, a good byte was dropped because the FIFO was full
//   i_ClearErr : synchronous clear of o_Overflow
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLOCK     = 50000000,
    parameter int unsigned UART_BAUDRATE = 115200,
    parameter int unsigned FIFO_DEPTH    = 16
) (
    input  logic                          i_SysClock,
    input  logic                          i_ResetN,
    input  logic                          i_RxSerial,
    output logic [7:0]                    o_RxByte,
    output logic                          o_RxValid,
    input  logic                          i_RxReady,
    output logic [$clog2(FIFO_DEPTH):0]   o_Count,
    output logic                          o_FrameErr,
    output logic                          o_Overflow,
    input  logic                          i_ClearErr
);

    localparam int unsigned ClksPerBit = clks_per_bit(SYS_CLOCK, UART_BAUDRATE);
    localparam int unsigned MidCnt     = mid_count(ClksPerBit);
    localparam int unsigned CntW       = $clog2(ClksPerBit);
    localparam int unsigned BitIdxW    = $clog2(DataBits);

    localparam logic [CntW-1:0]    CntLast   = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0]    CntSamp0  = CntW'(MidCnt - 1);
    localparam logic [CntW-1:0]    CntSamp1  = CntW'(MidCnt);
    localparam logic [CntW-1:0]    CntDecide = CntW'(MidCnt + 1);
    localparam logic [BitIdxW-1:0] LastBit   = BitIdxW'(DataBits - 1);

    rx_state_e             state_q, state_d;
    logic                  sync1_q, sync2_q, line_prev_q;
    logic                  line;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [1:0]            samp_q, samp_d;
    logic [BitIdxW-1:0]    bit_idx_q, bit_idx_d;
    logic [DataBits-1:0]   shift_q, shift_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overflow_q, overflow_d;
    logic                  decide, maj;
    logic                  push_req;
    logic                  fifo_full, fifo_empty;

    assign line   = sync2_q;
    assign decide = (cnt_q == CntDecide);
    // Two early samples plus the live line value at MID+1.
    assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & line) | (samp_q[1] & line);

    // State register
    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (line_prev_q && !line) state_d = StStart;
            StStart: if (decide) state_d = maj ? StIdle : StData;
            StData:  if (decide && (bit_idx_q == LastBit)) state_d = StStop;
            StStop:  if (decide) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        push_req    = 1'b0;
        frame_err_d = 1'b0;
        if ((state_q == StStop) && decide) begin
            if (maj) begin
                push_req = 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    // Bit timing, sampling and shift register
    always_comb begin
        cnt_d     = ((state_q == StIdle) || (cnt_q == CntLast)) ? '0 : cnt_q + CntW'(1);
        samp_d    = samp_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        if (cnt_q == CntSamp0) samp_d[0] = line;
        if (cnt_q == CntSamp1) samp_d[1] = line;
        if (state_q == StStart) begin
            bit_idx_d = '0;
        end else if ((state_q == StData) && decide) begin
            bit_idx_d = bit_idx_q + BitIdxW'(1);
            shift_d   = {maj, shift_q[DataBits-1:1]};
        end
    end

    // Overflow: set beats clear; a pop in the same cycle means nothing was dropped.
    always_comb begin
        if (push_req && fifo_full && !i_RxReady) begin
            overflow_d = 1'b1;
        end else if (i_ClearErr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            line_prev_q <= 1'b1;
            cnt_q       <= '0;
            samp_q      <= 2'b11;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync1_q     <= i_RxSerial;
            sync2_q     <= sync1_q;
            line_prev_q <= sync2_q;
            cnt_q       <= cnt_d;
            samp_q      <= samp_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (DataBits),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_SysClock),
        .rst_ni  (i_ResetN),
        .push_i  (push_req),
        .wdata_i (shift_q),
        .pop_i   (i_RxReady),
        .rdata_o (o_RxByte),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (o_Count)
    );

    assign o_RxValid  = !fifo_empty;
    assign o_FrameErr = frame_err_q;
    assign o_Overflow = overflow_q;

endmodule
